// File: rtl/hdb3_enc_if.sv
// rtl/hdb3_enc_if.sv - NRZ symbol strobe input and HDB3 rail/code output bundle
interface hdb3_enc_if;
   logic       in_valid;
   logic       in_data;
   logic       out_valid;
   logic       hdb3_p;
   logic       hdb3_n;
   logic [1:0] hdb3_code;

   modport master (
      output in_valid, in_data,
      input  out_valid, hdb3_p, hdb3_n, hdb3_code
   );

   modport slave (
      input  in_valid, in_data,
      output out_valid, hdb3_p, hdb3_n, hdb3_code
   );
endinterface

// File: rtl/hdb3_enc.sv
// rtl/hdb3_enc.sv - HDB3 line encoder with 4-symbol zero-substitution window
// Define HDB3_RZ_EN for return-to-zero rails (pulse high for SYM_CLKS/2 clks).
module hdb3_enc #(
   parameter int SYM_CLKS   = 8,
   parameter int PIPE_DEPTH = 4
) (
   input  logic      clk,
   input  logic      reset_n,
   hdb3_enc_if.slave bus
);
   localparam logic [1:0] CODE_ZERO = 2'b00;
   localparam logic [1:0] CODE_ONE  = 2'b01;
   localparam logic [1:0] CODE_B    = 2'b10;
   localparam logic [1:0] CODE_V    = 2'b11;
   localparam logic [2:0] FILL_FULL = 3'(PIPE_DEPTH);

   typedef struct packed {
      logic       valid;
      logic [1:0] code;
   } entry_t;

   entry_t [PIPE_DEPTH-1:0] win_q, win_d;
   logic [2:0] fill_q, fill_d;
   logic       last_pol_q, last_pol_d;   // 1: last mark went out on the P rail
   logic       parity_q, parity_d;       // 1: odd number of marks since the last V
   logic       emit, all_zero, rail_p_d, rail_n_d, rz_clear;
   logic [1:0] emit_code;
   logic       out_valid_q, rail_p_q, rail_n_q;
   logic [1:0] code_q;

   if (PIPE_DEPTH != 4 || SYM_CLKS < 2) begin : g_cfg_check
      $error("hdb3_enc: PIPE_DEPTH must be 4 and SYM_CLKS at least 2");
   end

   always_comb begin
      win_d      = win_q;
      fill_d     = fill_q;
      last_pol_d = last_pol_q;
      parity_d   = parity_q;
      emit       = 1'b0;
      emit_code  = CODE_ZERO;
      rail_p_d   = 1'b0;
      rail_n_d   = 1'b0;
      all_zero   = 1'b1;
      if (bus.in_valid) begin
         emit      = win_q[PIPE_DEPTH-1].valid && (fill_q == FILL_FULL);
         emit_code = win_q[PIPE_DEPTH-1].code;
         if (emit) begin
            case (emit_code)
               CODE_ONE, CODE_B: begin
                  rail_p_d   = ~last_pol_q;
                  rail_n_d   = last_pol_q;
                  last_pol_d = ~last_pol_q;
                  parity_d   = ~parity_q;
               end
               CODE_V: begin
                  rail_p_d = last_pol_q;
                  rail_n_d = ~last_pol_q;
                  parity_d = 1'b0;
               end
               default: ;
            endcase
         end
         for (int i = PIPE_DEPTH - 1; i > 0; i--) begin
            win_d[i] = win_q[i-1];
         end
         win_d[0].valid = 1'b1;
         win_d[0].code  = bus.in_data ? CODE_ONE : CODE_ZERO;
         // Substituted B/V entries are non-ZERO, so they can never re-trigger.
         for (int i = 0; i < PIPE_DEPTH; i++) begin
            if (!win_d[i].valid || win_d[i].code != CODE_ZERO) begin
               all_zero = 1'b0;
            end
         end
         if (all_zero) begin
            win_d[0].code = CODE_V;
            if (!parity_d) begin
               win_d[PIPE_DEPTH-1].code = CODE_B;
            end
         end
         if (fill_q != FILL_FULL) begin
            fill_d = fill_q + 3'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         win_q      <= '0;
         fill_q     <= 3'd0;
         last_pol_q <= 1'b0;
         parity_q   <= 1'b0;
      end else begin
         win_q      <= win_d;
         fill_q     <= fill_d;
         last_pol_q <= last_pol_d;
         parity_q   <= parity_d;
      end
   end

`ifdef HDB3_RZ_EN
   localparam int RZ_HALF = SYM_CLKS / 2;
   localparam int RZ_W    = $clog2(RZ_HALF + 1);

   logic [RZ_W-1:0] rz_cnt_q;

   // Counts clks since the last emission, parking once the pulse half has elapsed.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rz_cnt_q <= '0;
      end else if (emit) begin
         rz_cnt_q <= '0;
      end else if (rz_cnt_q != RZ_W'(RZ_HALF)) begin
         rz_cnt_q <= rz_cnt_q + RZ_W'(1);
      end
   end

   assign rz_clear = (rz_cnt_q == RZ_W'(RZ_HALF - 1));
`else
   assign rz_clear = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid_q <= 1'b0;
         rail_p_q    <= 1'b0;
         rail_n_q    <= 1'b0;
         code_q      <= CODE_ZERO;
      end else begin
         out_valid_q <= emit;
         if (emit) begin
            rail_p_q <= rail_p_d;
            rail_n_q <= rail_n_d;
            code_q   <= emit_code;
         end else if (rz_clear) begin
            rail_p_q <= 1'b0;
            rail_n_q <= 1'b0;
         end
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.hdb3_p    = rail_p_q;
   assign bus.hdb3_n    = rail_n_q;
   assign bus.hdb3_code = code_q;
endmodule

// File: tb/tb_hdb3_enc.sv
// tb/tb_hdb3_enc.sv - directed bench for hdb3_enc (define HDB3_RZ_EN to cover RZ rails)
module tb_hdb3_enc;
   localparam logic [4:0] NO_OUT = 5'b00000;
   localparam logic [4:0] E0     = 5'b10000;
   localparam logic [4:0] PO     = 5'b11001;
   localparam logic [4:0] NO     = 5'b10101;
   localparam logic [4:0] PB     = 5'b11010;
   localparam logic [4:0] NB     = 5'b10110;
   localparam logic [4:0] PV     = 5'b11011;
   localparam logic [4:0] NV     = 5'b10111;
`ifdef HDB3_RZ_EN
   localparam logic [4:0] HOLD_MASK = 5'b00011;
`else
   localparam logic [4:0] HOLD_MASK = 5'b01111;
`endif

   logic clk = 1'b0;
   logic reset_n;
   int   total = 0;
   int   bad   = 0;
   logic ov_prev = 1'b0;

   hdb3_enc_if bus ();

   hdb3_enc #(.SYM_CLKS(8), .PIPE_DEPTH(4)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   logic d1 [14] = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 1, 1};
   logic [4:0] x1 [14] = '{NO_OUT, NO_OUT, NO_OUT, NO_OUT, PO, E0, E0, E0, PV, NO, E0, E0, E0, NV};
   logic d2 [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
   logic [4:0] x2 [12] = '{NO_OUT, NO_OUT, NO_OUT, NO_OUT, PB, E0, E0, PV, NB, E0, E0, NV};
   logic [4:0] x3 [10] = '{NO_OUT, NO_OUT, NO_OUT, NO_OUT, PO, NO, PO, NO, PO, NO};
   logic d4 [8] = '{0, 0, 0, 0, 0, 1, 1, 1};
   logic [4:0] x4 [8] = '{NO_OUT, NO_OUT, NO_OUT, NO_OUT, PB, E0, E0, PV};

   function automatic logic [4:0] sample();
      return {bus.out_valid, bus.hdb3_p, bus.hdb3_n, bus.hdb3_code};
   endfunction

   task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic step(input string tag, input int idx, input logic d, input logic [4:0] exp);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk($sformatf("%s_emit[%0d]", tag, idx), sample(), exp);
      repeat (6) @(negedge clk);
      chk($sformatf("%s_hold[%0d]", tag, idx), sample(), exp & HOLD_MASK);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk(tag, sample(), NO_OUT);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   always @(negedge clk) begin
      total++;
      assert (!(bus.hdb3_p && bus.hdb3_n))
      else begin
         bad++;
         $error("FAIL rails_exclusive observed p=%b n=%b expected not both 1", bus.hdb3_p, bus.hdb3_n);
      end
      total++;
      assert (!(bus.out_valid && ov_prev))
      else begin
         bad++;
         $error("FAIL out_valid_width observed=2+ clks expected=1 clk");
      end
      ov_prev = bus.out_valid;
   end

   initial begin
      reset_n      = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_state", sample(), NO_OUT);
      reset_n = 1'b1;

      for (int i = 0; i < 14; i++) step("mixed", i, d1[i], x1[i]);

      do_reset("reset2");
      for (int i = 0; i < 12; i++) step("zeros", i, d2[i], x2[i]);

      do_reset("reset3");
      for (int i = 0; i < 10; i++) step("ones", i, 1'b1, x3[i]);

      do_reset("midstream_reset");
      for (int i = 0; i < 8; i++) step("resume", i, d4[i], x4[i]);

`ifdef HDB3_RZ_EN
      begin
         int p_cnt, n_cnt;
         do_reset("reset_rz");
         for (int i = 0; i < 4; i++) step("rz_fill", i, 1'b1, NO_OUT);
         for (int s = 0; s < 2; s++) begin
            p_cnt = 0;
            n_cnt = 0;
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = 1'b1;
            for (int c = 0; c < 8; c++) begin
               @(negedge clk);
               bus.in_valid = 1'b0;
               p_cnt += int'(bus.hdb3_p);
               n_cnt += int'(bus.hdb3_n);
            end
            chk($sformatf("rz_p_clks[%0d]", s), 5'(p_cnt), (s == 0) ? 5'd4 : 5'd0);
            chk($sformatf("rz_n_clks[%0d]", s), 5'(n_cnt), (s == 0) ? 5'd0 : 5'd4);
         end
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/hdb3_enc.md
Name: hdb3_enc

Overview:
- HDB3 line encoder; sits directly downstream of the baseband PN/clock generator.
- Consumes the NRZ bit stream, which arrives as a one-clock valid strobe per symbol plus a data bit.
- Emits the ternary HDB3 code as two unipolar rails (P/N) plus a symbol-code bus.
- Substitutes every run of 4 zeros with 000V or B00V.

Parameters:
- SYM_CLKS, 8, clk cycles per symbol period (strobe spacing); used only for RZ pulse width.
- PIPE_DEPTH, 4, lookahead window depth in symbols; fixed by the HDB3 rule, not to be overridden.

Ports:
- clk  in  1  system clock, single clock domain.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  one-clk strobe, one per symbol.
- in_data  in  1  NRZ bit, sampled when in_valid=1.
- out_valid  out  1  one-clk strobe; high the clk after an accepted in_valid once the window is full.
- hdb3_p  out  1  positive-pulse rail.
- hdb3_n  out  1  negative-pulse rail; never high together with hdb3_p.
- hdb3_code  out  2  code of the emitted symbol: 00 zero, 01 data one, 10 B, 11 V.

Behaviour:
- Reset (async, reset_n=0): all outputs 0; window entries invalid; fill=0; last_pol=NEG; parity=EVEN; RZ counter=0.
- Window: 4 entries w[3] (oldest) .. w[0]. Each entry holds {valid, code[1:0]}.
- Strobe (in_valid=1), single clk, in order:
  - (a) Emit w[3] if valid.
  - (b) Shift w[2:0] into w[3:1].
  - (c) Load w[0] = {1, in_data ? ONE : ZERO}.
  - (d) If all 4 entries are valid and raw ZERO, substitute: w[0] := V; w[3] := B if parity (after counting the symbol emitted in (a)) is EVEN, else stays ZERO.
- B/V entries never re-match a later substitution window; runs of 8 zeros give two independent substitutions.
- Fill: fill counts 0..4, saturating. No emission while fill<4 (out_valid stays 0).
- Latency: a bit accepted on strobe k is emitted on strobe k+4. Outputs are registered and update 1 clk after that strobe.
- Polarity, applied at emission:
  - ONE or B takes the polarity opposite to last_pol, then updates last_pol.
  - V takes the same polarity as last_pol; last_pol is unchanged.
  - ZERO drives both rails 0.
- Parity: counts ONE and B emissions since the last V; resets to EVEN on V emission.
- NRZ mode: rails and hdb3_code hold their value for the whole symbol period until the next emission.
- in_valid with no strobe: registers hold.
- reset_n asserted mid-stream: immediate clear. Resume needs 4 new strobes before out_valid.
- in_valid high on consecutive clks: each high clk is a strobe (no rate check).

Optional Feature:
- Macro: HDB3_RZ_EN.
- Defined:
  - A pulse counter restarts at each emission.
  - hdb3_p/hdb3_n are high only for the first SYM_CLKS/2 clks of the symbol, then 0 until the next emission.
  - hdb3_code still holds for the full period.
- Undefined: NRZ rails as above; no counter is synthesised.

Test Plan:
- Reset, then in_data stream 1,0,0,0,0,1,0,0,0,0 at one strobe per 8 clks:
  - Emitted P/N from 5th strobe: +,0,0,0,+V,-,0,0,0,-V.
  - hdb3_code: 01,00,00,00,11,01,00,00,00,11.
- Reset, then all zeros for 8 symbols:
  - Output: +B,0,0,+V,-B,0,0,-V.
  - Codes: 10,00,00,11,10,00,00,11.
- Reset, then all ones: alternating +,-,+,-…, never a V.
  - out_valid first high 1 clk after the 5th strobe.
- Pull reset_n low mid-stream, release, then feed 0,0,0,0,0:
  - Outputs are 0 during reset.
  - No output before 4 new strobes.
  - First emitted run starts +B (parity EVEN, last_pol NEG).
- With HDB3_RZ_EN and SYM_CLKS=8, feed 1,1:
  - hdb3_p high for exactly 4 clks, then low 4 clks.
  - hdb3_n then high for exactly 4 clks.
- Assertion over all tests: hdb3_p & hdb3_n never both 1; out_valid pulse width is exactly 1 clk.
